// File: rtl/l2_ram_bank_array.sv
// Interleaved L2 bank array: one SRAM per channel, range-checked decode, zero-scrub
// sequencer and a LATENCY-deep response pipeline per channel.
module l2_ram_bank_array #(
    parameter int unsigned NB_BANKS      = 4,
    parameter int unsigned BANK_WORDS    = 32768,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter logic [31:0] START_ADDR    = 32'h1C00_0000,
    parameter int unsigned LATENCY       = 1,
    parameter bit          INIT_ON_RESET = 1'b1
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic [NB_BANKS-1:0]                    req_i,
    input  logic [NB_BANKS-1:0][31:0]              add_i,
    input  logic [NB_BANKS-1:0]                    wen_i,
    input  logic [NB_BANKS-1:0][DATA_WIDTH/8-1:0]  be_i,
    input  logic [NB_BANKS-1:0][DATA_WIDTH-1:0]    wdata_i,
    output logic [NB_BANKS-1:0]                    gnt_o,
    output logic [NB_BANKS-1:0]                    r_valid_o,
    output logic [NB_BANKS-1:0]                    r_opc_o,
    output logic [NB_BANKS-1:0][DATA_WIDTH-1:0]    r_rdata_o,
    input  logic                                   init_req_i,
    output logic                                   init_done_o
);

    // state      | meaning
    // RESET_IDLE | reserved, never entered; treated as illegal
    // INIT       | scrub: every bank writes zero at row_cnt_q each cycle
    // READY      | normal service, requests granted without wait states

    localparam int unsigned BE_W  = DATA_WIDTH / 8;
    localparam int unsigned BSEL  = $clog2(NB_BANKS);
    localparam int unsigned WOFF  = $clog2(BE_W);
    localparam int unsigned ROW_W = $clog2(BANK_WORDS);
    localparam logic [32:0] REGION_BYTES = 33'(64'(NB_BANKS) * 64'(BANK_WORDS) * 64'(BE_W));
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(BANK_WORDS - 1);

    typedef enum logic [1:0] {
        RESET_IDLE = 2'd0,
        INIT       = 2'd1,
        READY      = 2'd2
    } state_t;

    localparam state_t RST_STATE = INIT_ON_RESET ? INIT : READY;

    state_t           state_q, state_d;
    logic [ROW_W-1:0] row_cnt_q, row_cnt_d;
    logic             ready;
    logic             scrub;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= RST_STATE;
            row_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            row_cnt_q <= row_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        row_cnt_d = row_cnt_q;
        case (state_q)
            INIT: begin
                row_cnt_d = row_cnt_q + 1'b1;
                if (row_cnt_q == LAST_ROW) begin
                    state_d   = READY;
                    row_cnt_d = '0;
                end
            end
            READY: begin
                if (init_req_i) begin
                    state_d = INIT;
                end
            end
            default: begin
                state_d   = READY;
                row_cnt_d = '0;
            end
        endcase
    end

    assign ready       = (state_q == READY);
    assign scrub       = (state_q == INIT) & ~rst_i;
    assign init_done_o = ready;
    assign gnt_o       = req_i & {NB_BANKS{ready & ~rst_i}};

    for (genvar g = 0; g < NB_BANKS; g++) begin : g_bank
        logic [31:0]            off;
        logic                   in_range;
        logic [ROW_W-1:0]       row_addr;
        logic                   acc;
        logic                   mem_we;
        logic                   mem_re;
        logic [ROW_W-1:0]       mem_row;
        logic [BE_W-1:0]        mem_be;
        logic [DATA_WIDTH-1:0]  mem_wdata;
        logic [DATA_WIDTH-1:0]  mem [BANK_WORDS];
        logic [DATA_WIDTH-1:0]  q;
        logic                   rd_q;
        logic [LATENCY-1:0]     v_q;
        logic [LATENCY-1:0]     opc_q;
        logic [DATA_WIDTH-1:0]  d0;
        logic [DATA_WIDTH-1:0]  d_out;
        logic                   unused_off;

        // Bank-select and high offset bits only feed the range check.
        assign off        = add_i[g] - START_ADDR;
        assign unused_off = ^off;
        assign in_range   = (add_i[g] >= START_ADDR) && ({1'b0, off} < REGION_BYTES);
        assign row_addr   = off[WOFF+BSEL+ROW_W-1 -: ROW_W];

        assign acc       = gnt_o[g] & in_range;
        assign mem_we    = scrub | (acc & ~wen_i[g]);
        assign mem_re    = acc & wen_i[g];
        assign mem_row   = scrub ? row_cnt_q : row_addr;
        assign mem_be    = scrub ? '1 : be_i[g];
        assign mem_wdata = scrub ? '0 : wdata_i[g];

        always_ff @(posedge clk_i) begin
            if (mem_we) begin
                for (int b = 0; b < BE_W; b++) begin
                    if (mem_be[b]) begin
                        mem[mem_row][b*8 +: 8] <= mem_wdata[b*8 +: 8];
                    end
                end
            end
            if (mem_re) begin
                q <= mem[mem_row];
            end
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                rd_q  <= 1'b0;
                v_q   <= '0;
                opc_q <= '0;
            end else begin
                rd_q     <= mem_re;
                v_q[0]   <= gnt_o[g];
                opc_q[0] <= gnt_o[g] & wen_i[g] & ~in_range;
                for (int k = 1; k < LATENCY; k++) begin
                    v_q[k]   <= v_q[k-1];
                    opc_q[k] <= opc_q[k-1];
                end
            end
        end

        // q is only meaningful for in-range reads; writes and errors return zero.
        assign d0 = rd_q ? q : '0;

        if (LATENCY == 1) begin : g_lat1
            assign d_out = d0;
        end else begin : g_latn
            logic [DATA_WIDTH-1:0] d_q [LATENCY-1];

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    for (int k = 0; k < LATENCY - 1; k++) begin
                        d_q[k] <= '0;
                    end
                end else begin
                    d_q[0] <= d0;
                    for (int k = 1; k < LATENCY - 1; k++) begin
                        d_q[k] <= d_q[k-1];
                    end
                end
            end

            assign d_out = d_q[LATENCY-2];
        end

        assign r_valid_o[g] = v_q[LATENCY-1];
        assign r_opc_o[g]   = opc_q[LATENCY-1];
        assign r_rdata_o[g] = v_q[LATENCY-1] ? d_out : '0;
    end

endmodule

// File: tb/tb_l2_ram_bank_array.sv
// Directed bench for l2_ram_bank_array: grants checked at issue, responses checked
// against a per-channel scoreboard of (due cycle, opc, data) entries.
module tb_l2_ram_bank_array;

    localparam int          NB   = 4;
    localparam int          BW   = 16;
    localparam int          DW   = 32;
    localparam int          LAT  = 2;
    localparam logic [31:0] BASE = 32'h1C00_0000;

    logic                   clk_i = 1'b0;
    logic                   rst_i = 1'b1;
    logic [NB-1:0]          req_i = '0;
    logic [NB-1:0][31:0]    add_i = '0;
    logic [NB-1:0]          wen_i = '1;
    logic [NB-1:0][3:0]     be_i = '0;
    logic [NB-1:0][DW-1:0]  wdata_i = '0;
    logic [NB-1:0]          gnt_o;
    logic [NB-1:0]          r_valid_o;
    logic [NB-1:0]          r_opc_o;
    logic [NB-1:0][DW-1:0]  r_rdata_o;
    logic                   init_req_i = 1'b0;
    logic                   init_done_o;

    l2_ram_bank_array #(
        .NB_BANKS(NB), .BANK_WORDS(BW), .DATA_WIDTH(DW),
        .START_ADDR(BASE), .LATENCY(LAT), .INIT_ON_RESET(1'b1)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .add_i(add_i), .wen_i(wen_i),
        .be_i(be_i), .wdata_i(wdata_i), .gnt_o(gnt_o), .r_valid_o(r_valid_o),
        .r_opc_o(r_opc_o), .r_rdata_o(r_rdata_o), .init_req_i(init_req_i),
        .init_done_o(init_done_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic        opc;
        logic [31:0] data;
    } rsp_t;

    rsp_t        sb[NB][$];
    logic [31:0] mdl[NB][BW];
    int          errors = 0;
    int          checks = 0;
    int          grants = 0;
    int          resps = 0;
    bit          exp_ready = 1'b0;
    bit          start_scrub = 1'b0;
    int          scrub_left = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clk_i) begin : mon
        rsp_t r;
        if (!rst_i) begin
            for (int c = 0; c < NB; c++) begin
                if (sb[c].size() > 0 && sb[c][0].due == cyc) begin
                    r = sb[c].pop_front();
                    resps++;
                    chk($sformatf("r_valid ch%0d", c), 32'(r_valid_o[c]), 32'd1);
                    chk($sformatf("r_opc ch%0d", c), 32'(r_opc_o[c]), 32'(r.opc));
                    chk($sformatf("r_rdata ch%0d", c), r_rdata_o[c], r.data);
                end else begin
                    chk($sformatf("idle r_valid ch%0d", c), 32'(r_valid_o[c]), 32'd0);
                end
            end
        end
    end

    task automatic drive(int ch, bit wr, logic [31:0] a, logic [3:0] b, logic [31:0] d);
        req_i[ch]   = 1'b1;
        wen_i[ch]   = ~wr;
        add_i[ch]   = a;
        be_i[ch]    = b;
        wdata_i[ch] = d;
    endtask

    function automatic logic [31:0] row_addr(int ch, int row);
        return BASE + 32'(row << 4) + 32'(ch << 2);
    endfunction

    // Check grants and init_done a little after the inputs settle, then record expectations.
    task automatic eval();
        logic [31:0] off;
        bit          inr;
        bit          g;
        int          row;
        #1;
        chk("init_done", 32'(init_done_o), 32'(exp_ready));
        for (int c = 0; c < NB; c++) begin
            g = req_i[c] & exp_ready & ~rst_i;
            chk($sformatf("gnt ch%0d", c), 32'(gnt_o[c]), 32'(g));
            if (g) begin
                grants++;
                off = add_i[c] - BASE;
                inr = (add_i[c] >= BASE) && (off < 32'(NB * BW * 4));
                row = int'(off[7:4]);
                if (wen_i[c]) begin
                    sb[c].push_back('{cyc + LAT, ~inr, inr ? mdl[c][row] : 32'h0});
                end else begin
                    if (inr) begin
                        for (int b = 0; b < 4; b++) begin
                            if (be_i[c][b]) mdl[c][row][b*8 +: 8] = wdata_i[c][b*8 +: 8];
                        end
                    end
                    sb[c].push_back('{cyc + LAT, 1'b0, 32'h0});
                end
            end
        end
        start_scrub = init_req_i & exp_ready & ~rst_i;
    endtask

    task automatic adv();
        @(negedge clk_i);
        req_i      = '0;
        init_req_i = 1'b0;
        if (start_scrub) begin
            exp_ready  = 1'b0;
            scrub_left = BW;
        end else if (scrub_left > 0) begin
            scrub_left--;
            if (scrub_left == 0) begin
                exp_ready = 1'b1;
                for (int c = 0; c < NB; c++)
                    for (int r = 0; r < BW; r++) mdl[c][r] = 32'h0;
            end
        end
        start_scrub = 1'b0;
    endtask

    task automatic tick();
        eval();
        adv();
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int g0;
        int r0;

        // reset values, with requests pending on every channel
        req_i = '1;
        repeat (3) @(negedge clk_i);
        #1;
        chk("rst gnt", 32'(gnt_o), 32'h0);
        chk("rst r_valid", 32'(r_valid_o), 32'h0);
        chk("rst r_opc", 32'(r_opc_o), 32'h0);
        chk("rst r_rdata", 32'(|r_rdata_o), 32'h0);
        chk("rst init_done", 32'(init_done_o), 32'h0);
        req_i = '0;

        // 1: scrub after reset, then first read of a scrubbed row
        @(negedge clk_i);
        rst_i      = 1'b0;
        exp_ready  = 1'b0;
        scrub_left = BW;
        for (int i = 0; i < BW; i++) begin
            drive(1, 1'b0, BASE + 32'h14, 4'hF, 32'h0);
            tick();
        end
        drive(1, 1'b0, BASE + 32'h14, 4'hF, 32'h0);
        tick();
        idle(3);

        // 2: byte-masked write, immediate read-back, neighbour row untouched
        drive(1, 1'b1, BASE + 32'h24, 4'b0101, 32'hDEADBEEF);
        tick();
        drive(1, 1'b0, BASE + 32'h24, 4'hF, 32'h0);
        tick();
        drive(1, 1'b0, BASE + 32'h14, 4'hF, 32'h0);
        tick();
        idle(3);

        // 3: out-of-range reads above and below the region; out-of-range write is dropped
        drive(0, 1'b0, BASE + 32'h100, 4'hF, 32'h0);
        drive(3, 1'b0, 32'h1BFF_FFFC, 4'hF, 32'h0);
        tick();
        drive(0, 1'b1, BASE + 32'h100, 4'hF, 32'h1234_5678);
        tick();
        drive(0, 1'b0, BASE, 4'hF, 32'h0);
        tick();
        idle(3);

        // 4: all channels, one request per cycle for 8 cycles
        g0 = grants;
        r0 = resps;
        for (int k = 0; k < 8; k++) begin
            for (int c = 0; c < NB; c++) begin
                if (k < 4) drive(c, 1'b1, row_addr(c, 8 + k), 4'hF, 32'hA500_0000 | 32'(c << 8) | 32'(k));
                else       drive(c, 1'b0, row_addr(c, 8 + k - 4), 4'hF, 32'h0);
            end
            tick();
        end
        idle(4);
        chk("burst grants", 32'(grants - g0), 32'd32);
        chk("burst responses", 32'(resps - r0), 32'd32);

        // 5: re-scrub with a read in flight; pulse during INIT is ignored
        drive(2, 1'b1, row_addr(2, 3), 4'hF, 32'hCAFE_F00D);
        tick();
        drive(2, 1'b0, row_addr(2, 3), 4'hF, 32'h0);
        init_req_i = 1'b1;
        tick();
        for (int i = 0; i < BW; i++) begin
            for (int c = 0; c < NB; c++) drive(c, 1'b0, row_addr(c, i), 4'hF, 32'h0);
            if (i == 5) init_req_i = 1'b1;
            tick();
        end
        drive(2, 1'b0, row_addr(2, 3), 4'hF, 32'h0);
        drive(1, 1'b0, BASE + 32'h24, 4'hF, 32'h0);
        drive(0, 1'b0, row_addr(0, 8), 4'hF, 32'h0);
        tick();
        idle(3);

        // 6: reset with two responses in the pipeline
        drive(0, 1'b0, row_addr(0, 1), 4'hF, 32'h0);
        tick();
        drive(1, 1'b0, row_addr(1, 1), 4'hF, 32'h0);
        eval();
        @(posedge clk_i);
        #1;
        rst_i     = 1'b1;
        req_i     = '0;
        exp_ready = 1'b0;
        #1;
        chk("mid-reset r_valid", 32'(r_valid_o), 32'h0);
        chk("mid-reset r_rdata", 32'(|r_rdata_o), 32'h0);
        for (int c = 0; c < NB; c++) sb[c].delete();
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i      = 1'b0;
        scrub_left = BW;
        idle(BW + 4);
        drive(3, 1'b0, row_addr(3, 7), 4'hF, 32'h0);
        tick();
        idle(4);

        for (int c = 0; c < NB; c++) chk($sformatf("drained ch%0d", c), 32'(sb[c].size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
